// File: rtl/io_port_pkg.sv
// io_port_pkg: shared defaults for the processor I/O port bridge.
//   IO_DATA_W     - word width of In_Port / Out_Port and the external links
//   IO_IN_DEPTH   - default input FIFO depth (power of 2, >= 2)
//   IO_OUT_DEPTH  - default output FIFO depth (power of 2, >= 2)
package io_port_pkg;

    localparam int IO_DATA_W    = 16;
    localparam int IO_IN_DEPTH  = 4;
    localparam int IO_OUT_DEPTH = 4;

endpackage : io_port_pkg

// File: rtl/port_fifo.sv
// port_fifo: synchronous FIFO with a combinational head taken from registered
// storage. When empty, head keeps showing the last popped word (0 after reset).
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push, din  - write request and word; ignored when full unless a pop is
//                accepted in the same cycle and ALLOW_FULL_PUSH_ON_POP = 1
//   pop        - read request; ignored when empty
//   head       - oldest word (or last popped word when empty)
//   count      - occupancy, 0..DEPTH
//   full/empty - occupancy flags from the registered count
module port_fifo
    import io_port_pkg::*;
#(
    parameter int DATA_W                 = IO_DATA_W,
    parameter int DEPTH                  = IO_IN_DEPTH,
    parameter bit ALLOW_FULL_PUSH_ON_POP = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? last_q : mem_q[rd_ptr_q];

    // The slot being freed by an accepted pop may be refilled in the same
    // cycle; the write lands on wr_ptr_q which equals rd_ptr_q when full,
    // and the old word is already captured into last_q.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | (ALLOW_FULL_PUSH_ON_POP & pop_ok));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: it is only visible through head while non-empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule : port_fifo

// File: rtl/io_port_bridge.sv
// io_port_bridge: external-side buffering for the processor's In_Port/Out_Port.
// Ports:
//   clk, RESET                              - clock, async active-high reset
//   ext_in_data/valid/ready                 - producer -> input FIFO
//   In_Port, in_avail, in_ack               - input FIFO head to processor
//   Out_Port, out_strobe                    - processor writes into output FIFO
//   ext_out_data/valid/ready                - output FIFO -> consumer
//   in_count, out_count                     - FIFO occupancies
//   in_underflow, out_overflow              - sticky error flags
module io_port_bridge
    import io_port_pkg::*;
#(
    parameter int DATA_W    = IO_DATA_W,
    parameter int IN_DEPTH  = IO_IN_DEPTH,
    parameter int OUT_DEPTH = IO_OUT_DEPTH
) (
    input  logic                          clk,
    input  logic                          RESET,
    input  logic [DATA_W-1:0]             ext_in_data,
    input  logic                          ext_in_valid,
    output logic                          ext_in_ready,
    output logic [DATA_W-1:0]             In_Port,
    output logic                          in_avail,
    input  logic                          in_ack,
    input  logic [DATA_W-1:0]             Out_Port,
    input  logic                          out_strobe,
    output logic [DATA_W-1:0]             ext_out_data,
    output logic                          ext_out_valid,
    input  logic                          ext_out_ready,
    output logic [$clog2(IN_DEPTH):0]     in_count,
    output logic [$clog2(OUT_DEPTH):0]    out_count,
    output logic                          in_underflow,
    output logic                          out_overflow
);

    logic in_full, in_empty;
    logic out_full, out_empty;
    logic in_underflow_q, in_underflow_d;
    logic out_overflow_q, out_overflow_d;

    // Ready depends only on the registered count, never on ext_in_valid.
    assign ext_in_ready  = ~in_full;
    assign in_avail      = ~in_empty;
    assign ext_out_valid = ~out_empty;

    port_fifo #(
        .DATA_W                 (DATA_W),
        .DEPTH                  (IN_DEPTH),
        .ALLOW_FULL_PUSH_ON_POP (1'b0)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (RESET),
        .push  (ext_in_valid & ~in_full),
        .din   (ext_in_data),
        .pop   (in_ack),
        .head  (In_Port),
        .count (in_count),
        .full  (in_full),
        .empty (in_empty)
    );

    // The processor cannot stall, so a strobe into a full FIFO is still
    // accepted when the consumer drains a word in the same cycle.
    port_fifo #(
        .DATA_W                 (DATA_W),
        .DEPTH                  (OUT_DEPTH),
        .ALLOW_FULL_PUSH_ON_POP (1'b1)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (RESET),
        .push  (out_strobe),
        .din   (Out_Port),
        .pop   (ext_out_ready & ~out_empty),
        .head  (ext_out_data),
        .count (out_count),
        .full  (out_full),
        .empty (out_empty)
    );

    always_comb begin
        in_underflow_d = in_underflow_q | (in_ack & in_empty);
        // Full implies valid, so a pop this cycle is just ext_out_ready.
        out_overflow_d = out_overflow_q | (out_strobe & out_full & ~ext_out_ready);
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            in_underflow_q <= 1'b0;
            out_overflow_q <= 1'b0;
        end else begin
            in_underflow_q <= in_underflow_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign in_underflow = in_underflow_q;
    assign out_overflow = out_overflow_q;

endmodule : io_port_bridge

// File: tb/tb_io_port_bridge.sv
module tb_io_port_bridge;

    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] ext_in_data = '0;
    logic        ext_in_valid = 1'b0;
    logic        ext_in_ready;
    logic [15:0] In_Port;
    logic        in_avail;
    logic        in_ack = 1'b0;
    logic [15:0] Out_Port = '0;
    logic        out_strobe = 1'b0;
    logic [15:0] ext_out_data;
    logic        ext_out_valid;
    logic        ext_out_ready = 1'b0;
    logic [2:0]  in_count;
    logic [2:0]  out_count;
    logic        in_underflow;
    logic        out_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] in_q[$];
    logic [15:0] out_q[$];
    logic [15:0] in_last;
    logic [15:0] out_last;

    io_port_bridge dut (
        .clk           (clk),
        .RESET         (RESET),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .In_Port       (In_Port),
        .in_avail      (in_avail),
        .in_ack        (in_ack),
        .Out_Port      (Out_Port),
        .out_strobe    (out_strobe),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .in_count      (in_count),
        .out_count     (out_count),
        .in_underflow  (in_underflow),
        .out_overflow  (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_in(input logic [15:0] w);
        chk("in_ready_pre", {31'd0, ext_in_ready}, {31'd0, (in_q.size() < 4)});
        if (in_q.size() < 4) in_q.push_back(w);
        ext_in_data  = w;
        ext_in_valid = 1'b1;
        step();
        ext_in_valid = 1'b0;
    endtask

    task automatic ack_in();
        chk("in_avail", {31'd0, in_avail}, 32'd1);
        chk("in_port", {16'd0, In_Port}, {16'd0, in_q[0]});
        in_last = in_q.pop_front();
        in_ack = 1'b1;
        step();
        in_ack = 1'b0;
    endtask

    task automatic strobe_out(input logic [15:0] w);
        if (out_q.size() < 4) out_q.push_back(w);
        Out_Port   = w;
        out_strobe = 1'b1;
        step();
        out_strobe = 1'b0;
    endtask

    task automatic drain_out();
        while (out_q.size() != 0) begin
            chk("out_valid", {31'd0, ext_out_valid}, 32'd1);
            chk("out_data", {16'd0, ext_out_data}, {16'd0, out_q[0]});
            out_last = out_q.pop_front();
            ext_out_ready = 1'b1;
            step();
            ext_out_ready = 1'b0;
        end
        chk("out_valid_empty", {31'd0, ext_out_valid}, 32'd0);
        chk("out_data_hold", {16'd0, ext_out_data}, {16'd0, out_last});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_last  = '0;
        out_last = '0;

        // Reset asserted mid-cycle, before any clock edge
        #3 RESET = 1'b1;
        #1;
        chk("rst_async_in_count", {29'd0, in_count}, 32'd0);
        step();
        step();
        RESET = 1'b0;
        step();
        chk("rst_in_port", {16'd0, In_Port}, 32'd0);
        chk("rst_in_avail", {31'd0, in_avail}, 32'd0);
        chk("rst_in_ready", {31'd0, ext_in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, ext_out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, ext_out_data}, 32'd0);
        chk("rst_out_count", {29'd0, out_count}, 32'd0);
        chk("rst_underflow", {31'd0, in_underflow}, 32'd0);
        chk("rst_overflow", {31'd0, out_overflow}, 32'd0);

        // Input ordering and 1-cycle latency
        push_in(16'h1111);
        chk("lat_avail", {31'd0, in_avail}, 32'd1);
        chk("lat_port", {16'd0, In_Port}, 32'h1111);
        push_in(16'h2222);
        push_in(16'h3333);
        chk("in_count3", {29'd0, in_count}, 32'd3);
        repeat (3) ack_in();
        chk("in_avail_done", {31'd0, in_avail}, 32'd0);
        chk("in_port_hold", {16'd0, In_Port}, 32'h3333);

        // Input full, then drain and underflow
        for (int i = 0; i < 5; i++) push_in(16'h5000 + 16'(i));
        chk("in_full_ready", {31'd0, ext_in_ready}, 32'd0);
        chk("in_full_count", {29'd0, in_count}, 32'd4);
        while (in_q.size() != 0) ack_in();
        in_ack = 1'b1;
        step();
        in_ack = 1'b0;
        chk("underflow", {31'd0, in_underflow}, 32'd1);
        chk("underflow_port", {16'd0, In_Port}, {16'd0, in_last});
        chk("underflow_count", {29'd0, in_count}, 32'd0);

        // Output overflow: fifth word dropped
        for (int i = 0; i < 5; i++) strobe_out(16'h00A0 + 16'(i));
        chk("out_full_count", {29'd0, out_count}, 32'd4);
        chk("overflow", {31'd0, out_overflow}, 32'd1);
        drain_out();

        // Reset mid-operation with both FIFOs half full
        push_in(16'h6001);
        push_in(16'h6002);
        strobe_out(16'h0E01);
        strobe_out(16'h0E02);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_in_count", {29'd0, in_count}, 32'd0);
        chk("mid_rst_out_count", {29'd0, out_count}, 32'd0);
        chk("mid_rst_avail", {31'd0, in_avail}, 32'd0);
        chk("mid_rst_valid", {31'd0, ext_out_valid}, 32'd0);
        chk("mid_rst_underflow", {31'd0, in_underflow}, 32'd0);
        chk("mid_rst_overflow", {31'd0, out_overflow}, 32'd0);
        in_q.delete();
        out_q.delete();
        step();
        RESET = 1'b0;
        step();

        // Traffic from empty after reset
        push_in(16'h7777);
        chk("post_rst_port", {16'd0, In_Port}, 32'h7777);
        ack_in();

        // Full output FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) strobe_out(16'h00C0 + 16'(i));
        chk("pp_pre_count", {29'd0, out_count}, 32'd4);
        chk("pp_head", {16'd0, ext_out_data}, {16'd0, out_q[0]});
        out_last = out_q.pop_front();
        out_q.push_back(16'hBEEF);
        Out_Port      = 16'hBEEF;
        out_strobe    = 1'b1;
        ext_out_ready = 1'b1;
        step();
        out_strobe    = 1'b0;
        ext_out_ready = 1'b0;
        chk("pp_count", {29'd0, out_count}, 32'd4);
        chk("pp_no_overflow", {31'd0, out_overflow}, 32'd0);
        drain_out();
        chk("pp_last_beef", {16'd0, out_last}, 32'hBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_io_port_bridge

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
External-side peripheral for the processor's 16-bit In_Port/Out_Port pair. Buffers words from an external producer into an input FIFO and presents the oldest word on In_Port. Captures every word the processor writes on Out_Port into an output FIFO, which an external consumer drains over a valid/ready handshake. Sits at the top level beside the Processor, one clock domain.

Parameters:
DATA_W, 16, word width of both ports
IN_DEPTH, 4, input FIFO entries (power of 2, >=2)
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
ext_in_data  in  DATA_W  word from external producer
ext_in_valid  in  1  producer offers ext_in_data
ext_in_ready  out  1  input FIFO not full
In_Port  out  DATA_W  head of input FIFO, to processor
in_avail  out  1  input FIFO non-empty
in_ack  in  1  processor consumed In_Port (IN executed); pops one entry
Out_Port  in  DATA_W  processor output word
out_strobe  in  1  processor wrote Out_Port this cycle (OUT executed)
ext_out_data  out  DATA_W  head of output FIFO
ext_out_valid  out  1  output FIFO non-empty
ext_out_ready  in  1  consumer accepts ext_out_data
in_count  out  $clog2(IN_DEPTH)+1  input FIFO occupancy
out_count  out  $clog2(OUT_DEPTH)+1  output FIFO occupancy
in_underflow  out  1  sticky: in_ack while empty
out_overflow  out  1  sticky: out_strobe while full and no pop

Behaviour:
- Reset: all FIFO pointers and counts 0; In_Port=0; ext_out_data=0; ext_in_ready=1; in_avail=0; ext_out_valid=0; both sticky flags 0. Reset is async-assert. A reset mid-transfer discards all buffered words.
- Input path: a push occurs when ext_in_valid & ext_in_ready at a rising edge. ext_in_ready = (in_count != IN_DEPTH), derived combinationally from registered count only, with no path from ext_in_valid.
- In_Port is driven from registered FIFO storage/pointers. A word pushed into an empty FIFO at edge N appears on In_Port, with in_avail=1, after edge N. Latency is 1 cycle.
- in_ack with in_avail=1 pops at the edge; the next word, or the held value, appears after that edge.
- When the FIFO is empty, In_Port holds the last popped value (0 after reset). in_ack while empty: no pointer change, in_underflow set.
- Input push and pop in the same cycle: both occur and the count is unchanged. When full, a simultaneous pop does NOT raise ext_in_ready within that cycle, because ready is based on the registered count.
- Output path: out_strobe pushes Out_Port when out_count != OUT_DEPTH, or when the FIFO is full and a pop (ext_out_valid & ext_out_ready) happens in the same cycle. Full-with-pop is accepted, since the processor cannot stall.
- out_strobe while full with no pop: the word is dropped, out_overflow is set, and no storage changes.
- ext_out_valid = (out_count != 0). ext_out_data is the head from registered storage. A pop occurs on valid & ready. Once valid is asserted, data stays stable until the pop.
- Push into an empty output FIFO at edge N: ext_out_valid=1 after N. A same-cycle push and pop on an empty FIFO is impossible because valid is 0.
- Pointers wrap modulo depth. Count arithmetic has width $clog2(DEPTH)+1, so count never exceeds DEPTH and never goes below 0.
- Sticky flags clear only on RESET.
- Ordering is strict FIFO on both paths, with no reordering or duplication.

Decomposition:
- Shared package io_port_pkg holds DATA_W default, and the IO_IN_DEPTH/IO_OUT_DEPTH defaults.
- One sub-module, port_fifo: parameterised synchronous FIFO (DATA_W, DEPTH) with push/pop, full/empty, count, and head output. It implements the "pop-allows-push-when-full" rule via a generic allow_full_push_on_pop parameter. It is instantiated twice: input path with the parameter =0, output path with =1.
- The top level adds the sticky flags and port mapping.

Test Plan:
- Reset/idle: assert RESET mid-cycle, release -> In_Port=0, in_avail=0, ext_in_ready=1, ext_out_valid=0, counts 0, flags 0.
- Input ordering: push 0x1111, 0x2222, 0x3333, then pulse in_ack three times.
  - In_Port sequence: 0x1111, 0x2222, 0x3333, with 1-cycle latency.
  - After the last ack, in_avail=0 and In_Port holds 0x3333.
- Input full/underflow: push 5 words with IN_DEPTH=4 -> ext_in_ready=0 after the 4th, 5th not accepted, in_count=4. Drain all, extra in_ack -> in_underflow=1, In_Port unchanged.
- Output overflow: ext_out_ready=0, strobe 0xA0..0xA4 -> out_count=4, out_overflow=1. Drain yields 0xA0..0xA3; 0xA4 is lost.
- Full push+pop: output FIFO full, out_strobe=0xBEEF with ext_out_ready=1 same cycle -> count stays 4, no overflow, 0xBEEF is the last drained word.
- Reset mid-operation: both FIFOs half full, pulse RESET -> counts 0, valid/avail low, subsequent traffic correct from empty.
